// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types, default polynomials and LFSR/MISR step functions for the BIST engine
// Purpose : FSM state enum, default polynomial/seed constants, and width-generic
//           step functions (operands carried in 64-bit containers, width <= 64).
// Ports   : none (package).
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_SHIFT,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_COMPARE,
        ST_DONE
    } bist_state_t;

    localparam logic [31:0] DEF_LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] DEF_LFSR_SEED = 32'h0000_0001;
    localparam logic [23:0] DEF_MISR_POLY = 24'h80_000D;

    // Fibonacci step, shifting towards bit 0: bit 0 is the serial output and
    // the parity of the tapped bits enters at bit width-1. Bits of state above
    // width must be zero; the caller truncates the result back to width.
    function automatic logic [63:0] lfsr_next(input logic [63:0] state,
                                              input logic [63:0] poly,
                                              input int unsigned width);
        logic fb;
        fb = ^(state & poly);
        return (state >> 1) | ({63'd0, fb} << (width - 1));
    endfunction

    // next = {m[width-2:0],0} ^ (m[width-1] ? poly : 0) ^ din; the caller
    // truncates the result back to width.
    function automatic logic [63:0] misr_next(input logic [63:0] m,
                                              input logic [63:0] poly,
                                              input logic [63:0] din,
                                              input int unsigned width);
        logic top;
        top = m[width - 1];
        return (m << 1) ^ (top ? poly : 64'd0) ^ din;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// rtl/bist_misr.sv - W-bit multiple-input signature register with clear and enable
// Purpose : compacts one W-bit word per enabled cycle into the signature.
// Ports   : clk, rst (sync, active high), clear (zero signature, beats enable),
//           enable (absorb data this cycle), data [W], sig [W] current signature.
module bist_misr
    import bist_pkg::*;
#(
    parameter int             W    = 24,
    parameter logic [W-1:0]   POLY = W'(DEF_MISR_POLY)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] data,
    output logic [W-1:0] sig
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sig <= '0;
        end else if (enable) begin
            sig <= W'(misr_next(64'(sig), 64'(POLY), 64'(data), W));
        end
    end

endmodule

// File: rtl/bist_pattern_engine.sv
// rtl/bist_pattern_engine.sv - logic-BIST driver: LFSR scan patterns, capture, MISR compaction, golden compare
// Purpose : runs NUM_PATTERNS shift/capture rounds on a full-scan CUT, unloads the
//           chain into the MISR and compares the signature against GOLDEN_SIG.
// Ports   : CK clock; RST sync active-high reset; start one-cycle run request;
//           busy run in progress; done run finished (held); pass signature==golden;
//           signature [PO_W] MISR; cut_pi [PI_W] registered CUT inputs;
//           cut_po [PO_W] CUT outputs; scan_en 1=shift 0=capture; scan_in/scan_out chain.
// Option  : BIST_DIAG_EN adds diag_pat (current pattern count) and diag_sig
//           (MISR snapshot taken at the end of each capture cycle).
module bist_pattern_engine
    import bist_pkg::*;
#(
    parameter int                 PI_W         = 35,
    parameter int                 PO_W         = 24,
    parameter int                 SCAN_LEN     = 19,
    parameter int                 NUM_PATTERNS = 256,
    parameter int                 LFSR_W       = 32,
    parameter logic [LFSR_W-1:0]  LFSR_POLY    = 32'h8020_0003,
    parameter logic [LFSR_W-1:0]  LFSR_SEED    = 32'h0000_0001,
    parameter logic [PO_W-1:0]    MISR_POLY    = 24'h80_000D,
    parameter logic [PO_W-1:0]    GOLDEN_SIG   = 24'h0
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [PO_W-1:0]   signature,
    output logic [PI_W-1:0]   cut_pi,
    input  logic [PO_W-1:0]   cut_po,
    output logic              scan_en,
    output logic              scan_in,
    input  logic              scan_out
`ifdef BIST_DIAG_EN
    ,
    output logic [$clog2(NUM_PATTERNS+1)-1:0] diag_pat,
    output logic [PO_W-1:0]                   diag_sig
`endif
);

    localparam int SC_W = $clog2(SCAN_LEN + 1);
    localparam int PC_W = $clog2(NUM_PATTERNS + 1);

    if (NUM_PATTERNS < 1) begin : g_bad_num_patterns
        $error("bist_pattern_engine: NUM_PATTERNS must be >= 1");
    end
    if (SCAN_LEN < 1) begin : g_bad_scan_len
        $error("bist_pattern_engine: SCAN_LEN must be >= 1");
    end
    if (LFSR_W > 64 || PO_W > 64) begin : g_bad_width
        $error("bist_pattern_engine: LFSR_W and PO_W must be <= 64");
    end

    bist_state_t        state;
    bist_state_t        state_nxt;
    logic [LFSR_W-1:0]  lfsr;
    logic [SC_W-1:0]    shift_cnt;
    logic [PC_W-1:0]    pat_cnt;
    logic [PI_W-1:0]    pi_rep;
    logic               last_shift;
    logic               last_pat;
    logic               accept;
    logic               misr_en;
    logic [PO_W-1:0]    misr_data;

    assign last_shift = (shift_cnt == SC_W'(SCAN_LEN - 1));
    assign last_pat   = (pat_cnt == PC_W'(NUM_PATTERNS - 1));
    // start is honoured only when no run is active
    assign accept     = start && (state == ST_IDLE || state == ST_DONE);

    assign busy    = (state != ST_IDLE) && (state != ST_DONE);
    assign done    = (state == ST_DONE);
    assign scan_en = (state != ST_CAPTURE);
    assign scan_in = (state == ST_SHIFT) && lfsr[0];

    // LFSR replicated cyclically across the PI bus
    always_comb begin
        pi_rep = '0;
        for (int i = 0; i < PI_W; i++) begin
            pi_rep[i] = lfsr[i % LFSR_W];
        end
    end

    always_comb begin
        state_nxt = state;
        misr_en   = 1'b0;
        misr_data = '0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_nxt = ST_SEED;
            end
            ST_SEED: state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                // chain content is undefined until the first capture has happened
                misr_en   = (pat_cnt != '0);
                misr_data = {{(PO_W-1){1'b0}}, scan_out};
                if (last_shift) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                misr_en   = 1'b1;
                misr_data = cut_po;
                state_nxt = last_pat ? ST_UNLOAD : ST_SHIFT;
            end
            ST_UNLOAD: begin
                misr_en   = 1'b1;
                misr_data = {{(PO_W-1){1'b0}}, scan_out};
                if (last_shift) state_nxt = ST_COMPARE;
            end
            ST_COMPARE: state_nxt = ST_DONE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state     <= ST_IDLE;
            lfsr      <= LFSR_SEED;
            shift_cnt <= '0;
            pat_cnt   <= '0;
            cut_pi    <= '0;
            pass      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE, ST_DONE: begin
                    // run setup happens on the accepting edge so the SEED
                    // cycle already shows the fresh state
                    if (start) begin
                        lfsr      <= LFSR_SEED;
                        shift_cnt <= '0;
                        pat_cnt   <= '0;
                        pass      <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    lfsr      <= LFSR_W'(lfsr_next(64'(lfsr), 64'(LFSR_POLY), LFSR_W));
                    shift_cnt <= last_shift ? '0 : shift_cnt + 1'b1;
                    if (last_shift) cut_pi <= pi_rep;
                end
                ST_CAPTURE: pat_cnt <= pat_cnt + 1'b1;
                ST_UNLOAD:  shift_cnt <= last_shift ? '0 : shift_cnt + 1'b1;
                ST_COMPARE: pass <= (signature == GOLDEN_SIG);
                default: ;
            endcase
        end
    end

    bist_misr #(
        .W    (PO_W),
        .POLY (MISR_POLY)
    ) u_misr (
        .clk    (CK),
        .rst    (RST),
        .clear  (accept),
        .enable (misr_en),
        .data   (misr_data),
        .sig    (signature)
    );

`ifdef BIST_DIAG_EN
    assign diag_pat = pat_cnt;

    // snapshot of the MISR value produced by the capture cycle
    always_ff @(posedge CK) begin
        if (RST) begin
            diag_sig <= '0;
        end else if (state == ST_CAPTURE) begin
            diag_sig <= PO_W'(misr_next(64'(signature), 64'(MISR_POLY), 64'(cut_po), PO_W));
        end
    end
`endif

endmodule

// File: tb/tb_bist_pattern_engine.sv
// tb/tb_bist_pattern_engine.sv - self-checking bench for bist_pattern_engine (SCAN_LEN=4, NUM_PATTERNS=3)
// Purpose : loopback golden run, injected capture fault, random scan/PO streams,
//           mid-run reset, start while busy, restart from DONE; diag ports when
//           BIST_DIAG_EN is defined.
// Ports   : none (top-level bench).
module tb_bist_pattern_engine;

    localparam int SL      = 4;
    localparam int NP      = 3;
    localparam int PI_W    = 35;
    localparam int PO_W    = 24;
    localparam int RUN_LEN = 1 + NP * (SL + 1) + SL + 1;
    localparam logic [31:0] L_POLY = 32'h8020_0003;
    localparam logic [31:0] L_SEED = 32'h0000_0001;
    localparam logic [23:0] M_POLY = 24'h80_000D;

    localparam int K_SEED = 0, K_SHIFT = 1, K_CAP = 2, K_UNLOAD = 3, K_CMP = 4;

    // LFSR state after n steps from the seed
    function automatic logic [31:0] lfsr_at(input int n);
        logic [31:0] s;
        s = L_SEED;
        for (int i = 0; i < n; i++) s = {^(s & L_POLY), s[31:1]};
        return s;
    endfunction

    function automatic logic [23:0] misr_step(input logic [23:0] m, input logic [23:0] d);
        return {m[22:0], 1'b0} ^ (m[23] ? M_POLY : 24'd0) ^ d;
    endfunction

    // Signature of a loopback run (scan_out=scan_in, cut_po=cut_pi[23:0]),
    // with cut_po[0] inverted at capture flip_p (0-based, -1 for none)
    function automatic logic [23:0] loop_sig(input int flip_p);
        logic [23:0] m;
        logic [31:0] t;
        m = '0;
        for (int p = 0; p < NP; p++) begin
            for (int j = 0; j < SL; j++) begin
                if (p > 0) begin
                    t = lfsr_at(p * SL + j);
                    m = misr_step(m, {23'd0, t[0]});
                end
            end
            t = lfsr_at(p * SL + SL - 1);
            m = misr_step(m, t[23:0] ^ ((p == flip_p) ? 24'd1 : 24'd0));
        end
        for (int j = 0; j < SL; j++) m = misr_step(m, 24'd0);
        return m;
    endfunction

    localparam logic [23:0] GOLD = loop_sig(-1);

    logic              CK, RST, start;
    logic              busy, done, pass, scan_en, scan_in;
    logic [PO_W-1:0]   signature;
    logic [PI_W-1:0]   cut_pi;
    wire  [PO_W-1:0]   cut_po;
    wire               scan_out;
    logic              loop_mode, flip, so_drv;
    logic [PO_W-1:0]   po_drv;
`ifdef BIST_DIAG_EN
    logic [1:0]        diag_pat;
    logic [PO_W-1:0]   diag_sig;
`endif

    assign cut_po   = loop_mode ? (cut_pi[23:0] ^ {23'd0, flip}) : po_drv;
    assign scan_out = loop_mode ? scan_in : so_drv;

    bist_pattern_engine #(
        .PI_W(PI_W), .PO_W(PO_W), .SCAN_LEN(SL), .NUM_PATTERNS(NP), .LFSR_W(32),
        .LFSR_POLY(L_POLY), .LFSR_SEED(L_SEED), .MISR_POLY(M_POLY), .GOLDEN_SIG(GOLD)
    ) dut (
        .CK(CK), .RST(RST), .start(start), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .cut_pi(cut_pi), .cut_po(cut_po), .scan_en(scan_en),
        .scan_in(scan_in), .scan_out(scan_out)
`ifdef BIST_DIAG_EN
        , .diag_pat(diag_pat), .diag_sig(diag_sig)
`endif
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    int checks = 0;
    int errors = 0;

    logic [23:0] po_tab [RUN_LEN];
    logic        so_tab [RUN_LEN];
    logic [23:0] mexp   [RUN_LEN + 1];   // MISR value at the start of each run cycle

    function automatic int kind_of(input int k);
        if (k == 0) return K_SEED;
        if (k <= NP * (SL + 1)) return (((k - 1) % (SL + 1)) == SL) ? K_CAP : K_SHIFT;
        if (k <= NP * (SL + 1) + SL) return K_UNLOAD;
        return K_CMP;
    endfunction

    function automatic logic [PI_W-1:0] rep(input logic [31:0] s);
        logic [PI_W-1:0] r;
        for (int i = 0; i < PI_W; i++) r[i] = s[i % 32];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic fill_random();
        for (int k = 0; k < RUN_LEN; k++) begin
            po_tab[k] = 24'($urandom);
            so_tab[k] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic fill_loop(input int flip_p);
        logic [31:0] t;
        for (int k = 0; k < RUN_LEN; k++) begin
            po_tab[k] = '0;
            so_tab[k] = 1'b0;
            if (kind_of(k) == K_SHIFT) begin
                t = lfsr_at(((k - 1) / (SL + 1)) * SL + (k - 1) % (SL + 1));
                so_tab[k] = t[0];
            end else if (kind_of(k) == K_CAP) begin
                t = lfsr_at(((k - 1) / (SL + 1)) * SL + SL - 1);
                po_tab[k] = t[23:0] ^ ((((k - 1) / (SL + 1)) == flip_p) ? 24'd1 : 24'd0);
            end
        end
    endtask

    task automatic build_expect();
        mexp[0] = '0;
        for (int k = 0; k < RUN_LEN; k++) begin
            case (kind_of(k))
                K_SHIFT:  mexp[k+1] = (((k - 1) / (SL + 1)) > 0) ? misr_step(mexp[k], {23'd0, so_tab[k]}) : mexp[k];
                K_CAP:    mexp[k+1] = misr_step(mexp[k], po_tab[k]);
                K_UNLOAD: mexp[k+1] = misr_step(mexp[k], {23'd0, so_tab[k]});
                default:  mexp[k+1] = mexp[k];
            endcase
        end
    endtask

    // One run; start re-pulsed at cycles sk1/sk2, RST at cycle rst_k (-1 = none),
    // scan_out driven X during the first pattern's shift when x_first is set.
    task automatic do_run(input string nm, input bit lp, input int flip_k, input int sk1,
                          input int sk2, input int rst_k, input bit x_first);
        logic [31:0] t;
        logic        exp_si;
        int          kd;
        loop_mode = lp;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < RUN_LEN; k++) begin
            kd     = kind_of(k);
            flip   = (k == flip_k);
            po_drv = po_tab[k];
            so_drv = so_tab[k];
            if (x_first && kd == K_SHIFT && k <= SL) so_drv = 1'bx;
            start  = (k == sk1) || (k == sk2);
            exp_si = 1'b0;
            if (kd == K_SHIFT) begin
                t = lfsr_at(((k - 1) / (SL + 1)) * SL + (k - 1) % (SL + 1));
                exp_si = t[0];
            end
            chk($sformatf("%s_busy_k%0d", nm, k), 64'(busy), 64'(1));
            chk($sformatf("%s_done_k%0d", nm, k), 64'(done), 64'(0));
            chk($sformatf("%s_scan_en_k%0d", nm, k), 64'(scan_en), 64'(kd != K_CAP));
            chk($sformatf("%s_scan_in_k%0d", nm, k), 64'(scan_in), 64'(exp_si));
            chk($sformatf("%s_sig_k%0d", nm, k), 64'(signature), 64'(mexp[k]));
`ifdef BIST_DIAG_EN
            if (k > 0 && kind_of(k - 1) == K_CAP) begin
                chk($sformatf("%s_diag_pat_k%0d", nm, k), 64'(diag_pat), 64'((k - 2) / (SL + 1) + 1));
                chk($sformatf("%s_diag_sig_k%0d", nm, k), 64'(diag_sig), 64'(mexp[k]));
            end
`endif
            if (k == rst_k) begin
                RST = 1'b1;
                step();
                RST   = 1'b0;
                start = 1'b0;
                chk($sformatf("%s_rst_busy", nm), 64'(busy), 64'(0));
                chk($sformatf("%s_rst_done", nm), 64'(done), 64'(0));
                chk($sformatf("%s_rst_sig", nm), 64'(signature), 64'(0));
                chk($sformatf("%s_rst_cut_pi", nm), 64'(cut_pi), 64'(0));
                chk($sformatf("%s_rst_scan_en", nm), 64'(scan_en), 64'(1));
`ifdef BIST_DIAG_EN
                chk($sformatf("%s_rst_diag_sig", nm), 64'(diag_sig), 64'(0));
`endif
                return;
            end
            step();
        end
        start = 1'b0;
        flip  = 1'b0;
        chk($sformatf("%s_end_busy", nm), 64'(busy), 64'(0));
        chk($sformatf("%s_end_done", nm), 64'(done), 64'(1));
        chk($sformatf("%s_end_sig", nm), 64'(signature), 64'(mexp[RUN_LEN]));
        chk($sformatf("%s_end_pass", nm), 64'(pass), 64'(mexp[RUN_LEN] == GOLD));
        chk($sformatf("%s_end_cut_pi", nm), 64'(cut_pi), 64'(rep(lfsr_at(NP * SL - 1))));
        step();
        chk($sformatf("%s_done_held", nm), 64'(done), 64'(1));
    endtask

    logic [23:0] prev_sig;

    initial begin
        RST = 1'b1; start = 1'b0; loop_mode = 1'b0; flip = 1'b0;
        po_drv = '0; so_drv = 1'b0;
        step();
        step();
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_pass", 64'(pass), 64'(0));
        chk("reset_sig", 64'(signature), 64'(0));
        chk("reset_cut_pi", 64'(cut_pi), 64'(0));
        chk("reset_scan_en", 64'(scan_en), 64'(1));
        chk("reset_scan_in", 64'(scan_in), 64'(0));
`ifdef BIST_DIAG_EN
        chk("reset_diag_pat", 64'(diag_pat), 64'(0));
        chk("reset_diag_sig", 64'(diag_sig), 64'(0));
`endif
        RST = 1'b0;
        step();

        // loopback run must hit the golden signature
        fill_loop(-1);
        build_expect();
        do_run("loop", 1'b1, -1, -1, -1, -1, 1'b0);
        chk("loop_pass", 64'(pass), 64'(1));

        // cut_po[0] inverted during capture 2 (cycle 10); restart from DONE
        fill_loop(1);
        build_expect();
        do_run("loopflip", 1'b1, 1 + (SL + 1) + SL, -1, -1, -1, 1'b0);
        chk("loopflip_pass", 64'(pass), 64'(0));

        // random streams, including start pulses while busy
        for (int r = 0; r < 3; r++) begin
            fill_random();
            build_expect();
            do_run($sformatf("rand%0d", r), 1'b0, -1, (r == 1) ? 3 : -1, (r == 1) ? 10 : -1, -1, 1'b0);
        end

        // reset mid-run, then a clean run on the same stimulus
        fill_random();
        build_expect();
        do_run("rstmid", 1'b0, -1, -1, -1, 8, 1'b0);
        step();
        do_run("after_rst", 1'b0, -1, -1, -1, -1, 1'b0);

        // first-pattern scan_out is X: must not be absorbed
        fill_random();
        build_expect();
        do_run("xfirst", 1'b0, -1, -1, -1, -1, 1'b1);

        // inverted scan_out during UNLOAD must change the signature
        prev_sig = mexp[RUN_LEN];
        for (int k = NP * (SL + 1) + 1; k <= NP * (SL + 1) + SL; k++) so_tab[k] = ~so_tab[k];
        build_expect();
        do_run("unload", 1'b0, -1, -1, -1, -1, 1'b0);
        chk("unload_sig_changed", 64'(signature != prev_sig), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
